param_fixed_priority_arbiter: RTL and testbench
===============================================

// Module: param_fixed_priority_arbiter
// PURPOSE
//   N-requester arbiter with a registered one-hot grant; the parametrised successor of the 3-line fixed-priority arbiter.
//   Fixed-priority (index 0 highest) or round-robin selection, optional grant lock (burst hold) with bounded hold time.
//   Sits in front of a shared resource (bus/memory port); requesters hold request high until served.
// PARAMETERS
//   N         4   number of requesters, N >= 2
//   RR_EN     0   0: fixed priority, lowest index wins; 1: round-robin, search starts after last granted index
//   LOCK_EN   1   1: holder keeps grant while its request stays high; 0: re-arbitrate every cycle
//   MAX_HOLD  16  max consecutive grant cycles for one holder when others are waiting; 0 = unlimited (LOCK_EN=1 only)
// PORTS
//   clk          in   1     single clock, rising edge
//   rst          in   1     synchronous, active-high reset
//   request      in   N     request lines, bit i = requester i
//   grant        out  N     registered one-hot grant, all-zero when idle
//   grant_valid  out  1     |grant, registered
//   grant_idx    out  IDXW  index of granted requester; IDXW = max(1,$clog2(N)); 0 when idle
// BEHAVIOUR
//   - Reset (rst high at edge): grant=0, grant_valid=0, grant_idx=0, state=IDLE, hold_cnt=0, rr_ptr=0.
//   - Latency: request sampled at edge k -> grant visible after edge k; grant only to a line high at that edge.
//   - grant always one-hot or zero; grant_valid/grant_idx always consistent with grant.
//   - FSM: IDLE, GRANTED.
//     IDLE: request==0 -> stay, grant=0; else -> GRANTED, grant=winner(request), hold_cnt=0.
//     GRANTED, LOCK_EN=0: every edge grant=winner(request); request==0 -> IDLE.
//     GRANTED, LOCK_EN=1:
//       request[idx] high, no forced release -> grant held, hold_cnt++ (saturating).
//       request[idx] low, others pending -> grant=winner(others) same edge, no idle bubble, hold_cnt=0.
//       request[idx] low, none pending -> IDLE, grant=0.
//       forced release: MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, other requests pending ->
//         grant=winner(request & ~grant), hold_cnt=0; holder gets exactly MAX_HOLD cycles.
//       holder alone: never forced off; hold_cnt saturates at MAX_HOLD-1.
//   - winner(): fixed -> lowest set index; RR -> first set index at/after rr_ptr, wrapping N-1 -> 0.
//   - rr_ptr <= (new grant idx + 1) mod N on every new grant; unchanged while held or idle.
//   - Fixed + LOCK_EN=0: higher index may starve (intended); RR bounds wait to N-1 grants.
//   - rst mid-grant: next edge all outputs to reset values; rst wins over all requests.
// STRUCTURE
//   - Package arb_pkg: state enum {IDLE, GRANTED}, clog2-min-1 index-width function, RR/fixed mode constants.
//   - Sub-module arb_prio_pick: combinational, in: req[N], mask[N]; out: onehot[N], idx, any.
//     Fixed: one instance, mask=all-ones (or ~grant for forced release).
//     RR: two instances, masked (index >= rr_ptr) and unmasked; masked result preferred if any.
//   - Top: FSM, hold_cnt, rr_ptr, output registers.
// TESTING (N=4, MAX_HOLD=4 unless stated)
//   1 Reset: rst=1 while grant=0100, request=1111 -> after edge grant=0000, valid=0, idx=0; held while rst=1.
//   2 Fixed, LOCK_EN=0: request=1010 -> grant=0010, idx=1; next request=1111 -> grant=0001 next edge.
//   3 Fixed, LOCK_EN=1: request=0100 -> 0100; request=0101 -> stays 0100; request=0001 -> 0001 next edge, no 0000 cycle.
//   4 Bounded hold: request=0011 steady from idle -> 0001 x4, 0010 x4, 0001 x4 ...; request=0001 alone -> 0001 indefinitely.
//   5 RR, LOCK_EN=0: request=1111 steady -> 0001,0010,0100,1000,0001 (wrap); request=1001 after grant 0010 -> 1000.
//   6 Empty/edge: request=0000 -> grant=0000, valid=0; single-cycle pulse request=0100 -> one grant cycle 0100, then 0000.
//   Checks every cycle: grant one-hot/zero, grant_valid==|grant, grant_idx matches grant, grant & ~prev-edge request == 0.

Source files
------------

// File: rtl/param_fixed_priority_arbiter_pkg.sv
// Shared types and helpers for the parametrised arbiter: FSM state, selection mode
// constants and the grant-index width function.
package arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Index width never drops below one bit, so a 2-requester arbiter still has an index port.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/param_fixed_priority_arbiter_pick.sv
// Combinational lowest-index picker over (req & mask); produces one-hot, index and any-set.
module arb_prio_pick
    import arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int IDXW = idx_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    mask,
    output logic [N-1:0]    onehot,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    logic [N-1:0] cand;

    assign cand = req & mask;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        // Scanning downwards lets the lowest set index overwrite any higher one.
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDXW'(i);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_fixed_priority_arbiter.sv
// N-requester arbiter with registered one-hot grant: fixed priority or round-robin,
// optional grant lock with a bounded hold time when other requesters are waiting.
module param_fixed_priority_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int RR_EN    = 0,
    parameter int LOCK_EN  = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             request,
    output logic [N-1:0]             grant,
    output logic                     grant_valid,
    output logic [idx_width(N)-1:0]  grant_idx
);

    localparam int IDXW      = idx_width(N);
    localparam int HCW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    state_t          state;
    logic [HCW-1:0]  hold_cnt;
    logic [IDXW-1:0] rr_ptr;

    logic [N-1:0]    excl_mask;
    logic [N-1:0]    ptr_mask;
    logic [N-1:0]    hi_onehot, all_onehot, win_onehot;
    logic [IDXW-1:0] hi_idx, all_idx, win_idx, next_ptr;
    logic            hi_any, all_any, win_any;
    logic            holder_req, others_req, forced, hold;

    // With lock on, the current holder is excluded so a release or forced handover picks someone else.
    always_comb begin
        excl_mask = (LOCK_EN != 0) ? ~grant : '1;
        ptr_mask  = '0;
        for (int i = 0; i < N; i++) begin
            ptr_mask[i] = (RR_EN == MODE_RR) && (i >= int'(rr_ptr));
        end
    end

    arb_prio_pick #(.N(N), .IDXW(IDXW)) u_pick_hi (
        .req    (request),
        .mask   (excl_mask & ptr_mask),
        .onehot (hi_onehot),
        .idx    (hi_idx),
        .any    (hi_any)
    );

    arb_prio_pick #(.N(N), .IDXW(IDXW)) u_pick_all (
        .req    (request),
        .mask   (excl_mask),
        .onehot (all_onehot),
        .idx    (all_idx),
        .any    (all_any)
    );

    // Requests at/after the pointer win first; otherwise wrap to the lowest index.
    assign win_onehot = hi_any ? hi_onehot : all_onehot;
    assign win_idx    = hi_any ? hi_idx    : all_idx;
    assign win_any    = hi_any | all_any;
    assign next_ptr   = (win_idx == IDXW'(N - 1)) ? '0 : win_idx + 1'b1;

    assign holder_req = |(request & grant);
    assign others_req = |(request & ~grant);
    assign forced     = (MAX_HOLD != 0) && (hold_cnt == HCW'(HOLD_LAST)) && others_req;
    assign hold       = (state == GRANTED) && (LOCK_EN != 0) && holder_req && !forced;

    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            hold_cnt    <= '0;
            rr_ptr      <= '0;
        end else if (hold) begin
            if (hold_cnt != HCW'(HOLD_LAST)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end else if (win_any) begin
            state       <= GRANTED;
            grant       <= win_onehot;
            grant_valid <= 1'b1;
            grant_idx   <= win_idx;
            hold_cnt    <= '0;
            rr_ptr      <= next_ptr;
        end else begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            hold_cnt    <= '0;
        end
    end

endmodule

// File: tb/tb_param_fixed_priority_arbiter.sv
// Drives five arbiter configurations from one request bus; directed vectors plus
// randomized traffic checked against an index-based behavioural model.
module tb_param_fixed_priority_arbiter;

    localparam int N  = 4;
    localparam int ND = 5;
    // 0: fixed/no-lock, 1: fixed/lock, 2: rr/no-lock, 3: rr/lock, 4: fixed/lock unlimited
    localparam int CFG_RR [ND] = '{0, 0, 1, 1, 0};
    localparam int CFG_LK [ND] = '{0, 1, 0, 1, 1};
    localparam int CFG_MH [ND] = '{4, 4, 4, 4, 0};

    logic         clk;
    logic         rst;
    logic [N-1:0] request;
    logic [N-1:0] gnt  [ND];
    logic         vld  [ND];
    logic [1:0]   gidx [ND];

    int n_tests = 0;
    int n_fail  = 0;

    int m_holder [ND];
    int m_run    [ND];
    int m_ptr    [ND];

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        int           dut;
        logic [N-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        param_fixed_priority_arbiter #(
            .N        (N),
            .RR_EN    (CFG_RR[g]),
            .LOCK_EN  (CFG_LK[g]),
            .MAX_HOLD (CFG_MH[g])
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .request     (request),
            .grant       (gnt[g]),
            .grant_valid (vld[g]),
            .grant_idx   (gidx[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: who holds the grant, for how many cycles, and where the RR search starts.
    task automatic model_step(input int d, input logic [N-1:0] rq, input logic rs);
        int  excl;
        int  start;
        int  w;
        bit  others;
        if (rs) begin
            m_holder[d] = -1;
            m_run[d]    = 0;
            m_ptr[d]    = 0;
            return;
        end
        excl   = (CFG_LK[d] != 0 && m_holder[d] >= 0) ? m_holder[d] : -1;
        others = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rq[i] && i != excl) others = 1'b1;
        end
        if (excl >= 0 && rq[excl] && !(CFG_MH[d] != 0 && m_run[d] >= CFG_MH[d] && others)) begin
            m_run[d]++;
            return;
        end
        start = (CFG_RR[d] != 0) ? m_ptr[d] : 0;
        w     = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (w < 0 && rq[i] && i != excl) w = i;
        end
        if (w < 0) begin
            m_holder[d] = -1;
            m_run[d]    = 0;
        end else begin
            m_holder[d] = w;
            m_run[d]    = 1;
            m_ptr[d]    = (w + 1) % N;
        end
    endtask

    task automatic apply_cycle(input logic rs, input logic [N-1:0] rq);
        logic [N-1:0] exp_g;
        rst     = rs;
        request = rq;
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            model_step(d, rq, rs);
            exp_g = (m_holder[d] < 0) ? '0 : N'(1) << m_holder[d];
            check($sformatf("model_grant d%0d", d), gnt[d], exp_g);
            check($sformatf("model_valid d%0d", d), vld[d], (m_holder[d] >= 0));
            check($sformatf("model_idx d%0d", d), gidx[d], (m_holder[d] < 0) ? 0 : m_holder[d]);
            check($sformatf("onehot0 d%0d", d), $onehot0(gnt[d]), 1);
            check($sformatf("valid_or d%0d", d), vld[d], |gnt[d]);
            check($sformatf("idx_match d%0d", d), gnt[d], vld[d] ? (N'(1) << gidx[d]) : N'(0));
            check($sformatf("grant_unrequested d%0d", d), gnt[d] & ~rq, 0);
        end
    endtask

    function automatic void add(input logic rs, input logic [N-1:0] rq, input int d, input logic [N-1:0] ex);
        vec_t v;
        v.rst = rs;
        v.req = rq;
        v.dut = d;
        v.exp = ex;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [N-1:0] rq;
        logic         rs;
        rst     = 1'b1;
        request = '0;
        for (int d = 0; d < ND; d++) begin
            m_holder[d] = -1;
            m_run[d]    = 0;
            m_ptr[d]    = 0;
        end

        // Reset, including reset arriving while a grant is held
        add(1, 4'b0000, 1, 4'b0000);
        add(0, 4'b0100, 1, 4'b0100);
        add(1, 4'b1111, 1, 4'b0000);
        add(1, 4'b1111, 1, 4'b0000);
        // Fixed priority without lock
        add(0, 4'b1010, 0, 4'b0010);
        add(0, 4'b1111, 0, 4'b0001);
        // Fixed priority with lock: handover without an idle bubble
        add(0, 4'b0100, 1, 4'b0100);
        add(0, 4'b0101, 1, 4'b0100);
        add(0, 4'b0001, 1, 4'b0001);
        add(0, 4'b0000, 1, 4'b0000);
        // Bounded hold, MAX_HOLD=4
        for (int k = 0; k < 4; k++) add(0, 4'b0011, 1, 4'b0001);
        for (int k = 0; k < 4; k++) add(0, 4'b0011, 1, 4'b0010);
        for (int k = 0; k < 4; k++) add(0, 4'b0011, 1, 4'b0001);
        for (int k = 0; k < 5; k++) add(0, 4'b0001, 1, 4'b0001);
        add(0, 4'b0011, 1, 4'b0010);
        // Round-robin without lock, wrap and pointer-relative search
        add(1, 4'b0000, 2, 4'b0000);
        add(0, 4'b1111, 2, 4'b0001);
        add(0, 4'b1111, 2, 4'b0010);
        add(0, 4'b1111, 2, 4'b0100);
        add(0, 4'b1111, 2, 4'b1000);
        add(0, 4'b1111, 2, 4'b0001);
        add(0, 4'b1111, 2, 4'b0010);
        add(0, 4'b1001, 2, 4'b1000);
        // Empty request and a single-cycle pulse
        add(0, 4'b0000, 2, 4'b0000);
        add(0, 4'b0100, 1, 4'b0100);
        add(0, 4'b0000, 1, 4'b0000);

        foreach (vecs[i]) begin
            apply_cycle(vecs[i].rst, vecs[i].req);
            check($sformatf("vector %0d d%0d", i, vecs[i].dut), gnt[vecs[i].dut], vecs[i].exp);
        end

        // Random traffic with sticky requests and occasional reset
        rq = '0;
        for (int c = 0; c < 2000; c++) begin
            rs = ($urandom_range(0, 63) == 0);
            rq = rq ^ (N'($urandom) & N'($urandom));
            if ($urandom_range(0, 31) == 0) rq = '0;
            apply_cycle(rs, rq);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
